// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester and memory-bus signal bundle for mem_bus_arbiter
//
// Purpose: groups the fetch port, the data port and the single-port memory bus
//          so they can be passed to the arbiter as one port.
// Modports:
//   master - the arbiter. It is the bus master towards memory, and it answers
//            the fetch and data requesters.
//   slave  - the environment. This covers the pipeline requesters and the
//            memory slave.
// Signals:
//   inst_req/inst_addr -> inst_rdata/inst_ready            fetch port (read only)
//   data_req/we/addr/wdata -> data_rdata/data_ready        data port
//   mem_req/we/addr/wdata -> mem_rdata/mem_ack             memory bus
//   bus_err                                                sticky timeout flag
interface mem_bus_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ready;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  modport master (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
    input  mem_rdata, mem_ack,
    output inst_rdata, inst_ready, data_rdata, data_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );

  modport slave (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_wdata,
    output mem_rdata, mem_ack,
    input  inst_rdata, inst_ready, data_rdata, data_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, bus_err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - fetch/data arbiter for a single-port memory bus with timeout
//
// Purpose: shares one req/ack memory bus between instruction fetch and data
//          access. Data requests normally win arbitration. After STARVE_MAX
//          consecutive data grants with fetch waiting, the next grant goes to
//          fetch. A bus transaction that sees no ack within TIMEOUT cycles is
//          aborted. An aborted transaction sets the sticky bus_err flag.
// Ports:
//   clk  - clock; all state changes on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - mem_bus_arbiter_if.master (fetch port, data port, memory bus, bus_err)
module mem_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.master   bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_D = 2'd1;
  localparam logic [1:0] GNT_I = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;
  logic [31:0]   data_rdata_q, data_rdata_d;
  logic          inst_ready_q, inst_ready_d;
  logic          data_ready_q, data_ready_d;
  logic          bus_err_q, bus_err_d;

  logic          fetch_starved;
  logic          is_data;

  assign fetch_starved = bus.inst_req && (starve_q == SW'(STARVE_MAX));
  assign is_data       = (state_q == GNT_D);

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    tmo_d        = tmo_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ready_d = 1'b0;   // ready pulses last exactly one cycle
    data_ready_d = 1'b0;
    bus_err_d    = bus_err_q;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (bus.data_req && !fetch_starved) begin
          state_d     = GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.data_we;
          mem_addr_d  = bus.data_addr;
          mem_wdata_d = bus.data_wdata;
          // Only grants that overtake a waiting fetch count towards starvation.
          if (!bus.inst_req)
            starve_d = '0;
          else if (starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + 1'b1;
        end else if (bus.inst_req) begin
          state_d     = GNT_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.inst_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end

      GNT_D, GNT_I: begin
        tmo_d = tmo_q + 1'b1;
        // An ack wins over a timeout that expires in the same cycle.
        if (bus.mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            if (is_data) data_rdata_d = bus.mem_rdata;
            else         inst_rdata_d = bus.mem_rdata;
          end
          if (is_data) data_ready_d = 1'b1;
          else         inst_ready_d = 1'b1;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th request cycle without an ack, so abort.
          state_d   = DONE;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!mem_we_q) begin
            if (is_data) data_rdata_d = 32'hDEADBEEF;
            else         inst_rdata_d = 32'hDEADBEEF;
          end
          if (is_data) data_ready_d = 1'b1;
          else         inst_ready_d = 1'b1;
        end
      end

      // The ready pulse is visible in this cycle. Requests are not sampled here,
      // so a request still high during its ready pulse is not granted again.
      DONE: begin
        tmo_d   = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      tmo_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      tmo_q        <= tmo_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.inst_rdata = inst_rdata_q;
  assign bus.data_rdata = data_rdata_q;
  assign bus.inst_ready = inst_ready_q;
  assign bus.data_ready = data_ready_q;
  assign bus.bus_err    = bus_err_q;

endmodule
